// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// wait-counter width and the address legality check.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Word-aligned and inside the storage; the word index is addr[31:2].
    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < $unsigned(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one write port, one registered read port, no reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: captures a load/store, stalls the pipeline for WAIT
// cycles, executes the access on the edge into RESP and pulses MemReady.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        StallM,
    output logic        AddrErr
);

    localparam int AW = $clog2(DEPTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      addr_reg, wdata_reg, rd_hold_reg;
    logic             write_reg, err_reg;

    logic             accept, exec, exec_ok, exec_write;
    logic [31:0]      exec_addr, exec_wdata, rdata;

    assign accept = (state_reg == ST_IDLE) && MemReqM;

    // With WAIT=0 the access executes on the accepting edge, so it must use
    // the live inputs instead of the (not yet loaded) capture registers.
    assign exec_addr  = (state_reg == ST_IDLE) ? ALUOutM    : addr_reg;
    assign exec_wdata = (state_reg == ST_IDLE) ? WriteDataM : wdata_reg;
    assign exec_write = (state_reg == ST_IDLE) ? MemWriteM  : write_reg;
    assign exec_ok    = addr_ok(exec_addr, DEPTH);
    assign exec       = !reset &&
                        (((state_reg == ST_WAIT) && (cnt_reg == CNT_W'(1))) ||
                         (accept && (WAIT == 0)));

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (exec && exec_write && exec_ok),
        .waddr (exec_addr[AW+1:2]),
        .wdata (exec_wdata),
        .raddr (exec_addr[AW+1:2]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            rd_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= ALUOutM;
                wdata_reg <= WriteDataM;
                write_reg <= MemWriteM;
            end
            if (exec) begin
                err_reg <= !exec_ok;
            end
            if (state_reg == ST_RESP) begin
                rd_hold_reg <= ReadData;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (MemReqM) begin
                    cnt_next   = CNT_W'(WAIT);
                    state_next = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Loads and errors present fresh data in RESP; a good store keeps the old value.
    always_comb begin
        MemReady = (state_reg == ST_RESP);
        AddrErr  = (state_reg == ST_RESP) && err_reg;
        StallM   = ((state_reg == ST_IDLE) && MemReqM) || (state_reg == ST_WAIT);
        ReadData = rd_hold_reg;
        if (state_reg == ST_RESP) begin
            if (err_reg) begin
                ReadData = '0;
            end else if (!write_reg) begin
                ReadData = rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT=2 and a WAIT=0 instance driven with directed
// and random requests, checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rd    [2];
    logic        rdy   [2];
    logic        stall [2];
    logic        err   [2];

    dmem_responder #(.DEPTH(64), .WAIT(2)) dut_a (
        .clk(clk), .reset(rst[0]), .MemReqM(req[0]), .MemWriteM(wr[0]),
        .ALUOutM(addr[0]), .WriteDataM(wdat[0]), .ReadData(rd[0]),
        .MemReady(rdy[0]), .StallM(stall[0]), .AddrErr(err[0])
    );

    dmem_responder #(.DEPTH(64), .WAIT(0)) dut_b (
        .clk(clk), .reset(rst[1]), .MemReqM(req[1]), .MemWriteM(wr[1]),
        .ALUOutM(addr[1]), .WriteDataM(wdat[1]), .ReadData(rd[1]),
        .MemReady(rdy[1]), .StallM(stall[1]), .AddrErr(err[1])
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl_mem [2][64];
    logic [31:0] mdl_rd  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 64);
    endfunction

    // One request on instance s; optionally scrambles inputs during WAIT.
    task automatic xact(input int s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
        int          wt;
        int          stalls;
        bit          done;
        bit          exp_err;
        logic [31:0] exp_rd;
        wt      = (s == 0) ? 2 : 0;
        exp_err = !legal(a);
        if (exp_err) begin
            exp_rd = 32'h0;
        end else if (w) begin
            mdl_mem[s][a / 4] = d;
            exp_rd = mdl_rd[s];
        end else begin
            exp_rd = mdl_mem[s][a / 4];
        end
        mdl_rd[s] = exp_rd;
        @(negedge clk);
        req[s] = 1'b1; wr[s] = w; addr[s] = a; wdat[s] = d;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (rdy[s]) begin
                done = 1'b1;
                chk("latency", 32'(k), 32'(wt + 1));
                chk("stall_in_resp", 32'(stall[s]), 32'h0);
                chk("stall_cycles", 32'(stalls), 32'(wt + 1));
                chk("readdata", rd[s], exp_rd);
                chk("addrerr", 32'(err[s]), 32'(exp_err));
                req[s] = 1'b0;
            end else begin
                if (stall[s]) stalls++;
                @(negedge clk);
                if (scramble && (k + 1) <= wt) begin
                    req[s] = 1'($urandom_range(0, 1)); wr[s] = 1'($urandom_range(0, 1));
                    addr[s] = $urandom; wdat[s] = $urandom;
                end
            end
        end
        if (!done) begin
            chk("ready_timeout", 32'(rdy[s]), 32'h1);
            req[s] = 1'b0;
        end
        $display("xact inst=%0d %s addr=%h data=%h exp_rd=%h exp_err=%0d", s,
                 w ? "ST" : "LD", a, d, exp_rd, exp_err);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 32'($urandom_range(0, 63)) * 4;
        else if (r < 9) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        else            return ($urandom | 32'h100) & 32'hFFFF_FFFC;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; req[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
            mdl_rd[s] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_readdata", rd[s], 32'h0);
            chk("reset_ready", 32'(rdy[s]), 32'h0);
            chk("reset_stall", 32'(stall[s]), 32'h0);
            chk("reset_addrerr", 32'(err[s]), 32'h0);
        end

        // Fill both storages so every later load has a known expectation.
        for (int i = 0; i < 64; i++) xact(0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 64; i++) xact(1, 1'b1, 32'(i * 4), $urandom, 1'b0);

        xact(0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0);
        xact(0, 1'b0, 32'h10,  32'h0, 1'b0);
        xact(0, 1'b0, 32'h12,  32'h0, 1'b0);
        xact(0, 1'b0, 32'h10,  32'h0, 1'b0);
        xact(0, 1'b1, 32'h100, 32'h12345678, 1'b0);
        xact(0, 1'b0, 32'h0,   32'h0, 1'b0);
        xact(0, 1'b1, 32'hFC,  32'h0BADF00D, 1'b0);
        xact(0, 1'b0, 32'hFC,  32'h0, 1'b0);
        xact(0, 1'b0, 32'h100, 32'h0, 1'b0);

        // Reset during WAIT drops the store.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        chk("prereset_stall", 32'(stall[0]), 32'h1);
        rst[0] = 1'b1; req[0] = 1'b0;
        #1;
        chk("inreset_ready", 32'(rdy[0]), 32'h0);
        chk("inreset_stall", 32'(stall[0]), 32'h0);
        chk("inreset_addrerr", 32'(err[0]), 32'h0);
        chk("inreset_readdata", rd[0], 32'h0);
        @(negedge clk);
        rst[0] = 1'b0;
        mdl_rd[0] = 32'h0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rdy[0]) seen++;
            @(negedge clk);
        end
        chk("dropped_ready_count", 32'(seen), 32'h0);
        $display("reset-in-wait store to 0x20 dropped, ready pulses=%0d", seen);
        xact(0, 1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++)
            xact(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b1);

        xact(1, 1'b0, 32'h8, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h9, 32'h0, 1'b0);

        // Continuous loads on the zero-wait instance: one accept every 2 cycles.
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h8;
        mdl_rd[1] = mdl_mem[1][2];
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stream_ready", 32'(rdy[1]), 32'(k % 2));
            chk("stream_stall", 32'(stall[1]), 32'(1 - k % 2));
            if (k % 2 == 1) chk("stream_readdata", rd[1], mdl_mem[1][2]);
            $display("stream cycle=%0d ready=%0d stall=%0d", k, rdy[1], stall[1]);
            if (k < 9) @(negedge clk);
        end
        req[1] = 1'b0;

        for (int i = 0; i < 60; i++)
            xact(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
